dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the M-stage memory interface of the pipelined RV32 core.
- Accepts load/store requests (address, store data, size from funct3[1:0]) and returns the raw aligned word same cycle; load lane extraction/sign-extension stays in the core's load decoder.
- Generates byte enables for sb/sh/sw, owns the RAM array, and hosts a small MMIO region: GPIO output register, 64-bit cycle counter and status register.

Parameters:
- MEM_WORDS, 1024, RAM depth in 32-bit words (power of two).
- GPIO_W, 8, width of GPIO output register (1..32).

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- we  in  1  store request (M stage)
- re  in  1  load request (M stage)
- addr  in  32  byte address (ALU result, M stage)
- wd  in  32  store data, right-justified
- size  in  2  funct3[1:0]: 00 byte, 01 half, 10 word, 11 treated as word
- rd  out  32  aligned read word, combinational
- gpio_out  out  GPIO_W  GPIO register contents
- misalign  out  1  sticky misalignment flag (0 when feature compiled out)

Behaviour:
- Reset (sync, active-high): gpio_out=0, cycle counter=0, misalign=0. RAM contents not reset. Reset mid-store: reset wins for MMIO registers; a RAM write in the same cycle still commits.
- Decode: addr[31]=0 -> RAM, word index addr[log2(MEM_WORDS)+1:2], upper bits ignored (aliasing/wrap). addr[31]=1 -> MMIO, offset addr[3:0]: 0x0 GPIO (r/w), 0x4 CYCLE_LO (ro), 0x8 CYCLE_HI (ro), 0xC STATUS (bit0=misalign, write-1-to-clear). Other offsets read 0, writes ignored.
- Read: rd combinational from addressed word regardless of re; latency 0 (data valid in the same M cycle). MMIO reads zero-extend GPIO to 32 bits.
- Store lane generation: size 00 -> be=0001<<addr[1:0], data={4{wd[7:0]}}. Size 01 -> be=addr[1]?1100:0011, data={2{wd[15:0]}}. Size 1x -> be=1111, data=wd. Only enabled bytes are written at the clock edge.
- GPIO writes honour byte enables (bytes above GPIO_W discarded). Writes to CYCLE_* are ignored.
- Cycle counter: 64-bit, increments every non-reset cycle, wraps 0xFFFF_FFFF_FFFF_FFFF -> 0. CYCLE_HI and CYCLE_LO are read independently (no snapshot).
- we and re both high: treated as a store; rd is still driven.
- Store then load to the same address in consecutive cycles: the load sees the new data (write committed at the edge).

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: misaligned = (size=01 & addr[0]) | (size[1] & addr[1:0]!=0), qualified by we|re. A misaligned store is suppressed (no RAM/MMIO write). misalign sets on the next edge and stays set until a STATUS write with wd[0]=1. Simultaneous set and clear: set wins.
- Undefined: no detection. Half stores ignore addr[0]; word stores ignore addr[1:0]. misalign tied 0 and STATUS reads 0.

Decomposition:
- Package dmem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), MMIO base bit, MMIO offsets (OFF_GPIO/OFF_CYC_LO/OFF_CYC_HI/OFF_STATUS), STATUS bit index.
- Sub-module store_lane_gen: combinational size+addr[1:0]+wd -> be[3:0], lane data[31:0], misaligned.

Test Plan:
- Reset, then sw 0xDEADBEEF @0x10, lw @0x10 -> rd=0xDEADBEEF; read CYCLE_LO twice N cycles apart -> difference N.
- sb 0xAA @0x11 over 0x00000000 -> word @0x10 reads 0x0000AA00; sh 0x1234 @0x12 -> 0x1234AA00.
- Aliasing: sw 0x55 @ (MEM_WORDS*4 + 0x8) -> lw @0x8 returns 0x55.
- GPIO: sb 0xFF @0x80000000 -> gpio_out=0xFF; assert reset mid-run -> gpio_out=0, counter restarts at 0.
- DMEM_MISALIGN_TRAP_EN: sw 0x1 @0x6 -> word @0x4 unchanged, misalign=1; write 1 to STATUS in the same cycle as a misaligned lh -> misalign stays 1; plain clear -> 0.
- Force counter to 0x00000000_FFFFFFFF -> next cycle CYCLE_HI=1, CYCLE_LO=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the M-stage data-memory responder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package dmem_pkg;

  // funct3[1:0] access size; 2'b11 behaves as a word access.
  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_WORD_X = 2'b11
  } size_e;

  // addr[MMIO_BIT] selects the MMIO window instead of RAM.
  localparam int MMIO_BIT = 31;

  // MMIO register offsets (addr[3:0]).
  localparam logic [3:0] OFF_GPIO   = 4'h0;
  localparam logic [3:0] OFF_CYC_LO = 4'h4;
  localparam logic [3:0] OFF_CYC_HI = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  // STATUS register bit holding the sticky misalignment flag.
  localparam int STATUS_MIS_BIT = 0;

endpackage

// File: rtl/dmem_responder_if.sv
// Core <-> data-memory bus for the M stage.
// Latency: rd is combinational from addr in the same cycle.
// Backpressure: none; every request is accepted in the cycle it is presented.
// Signals: we/re request strobes, addr byte address, wd right-justified store
// data, size funct3[1:0], rd aligned read word, gpio_out GPIO register,
// misalign sticky misalignment flag.
interface dmem_responder_if #(
  parameter int GPIO_W = 8
);
  logic              we;
  logic              re;
  logic [31:0]       addr;
  logic [31:0]       wd;
  logic [1:0]        size;
  logic [31:0]       rd;
  logic [GPIO_W-1:0] gpio_out;
  logic              misalign;

  modport master (
    output we, re, addr, wd, size,
    input  rd, gpio_out, misalign
  );

  modport slave (
    input  we, re, addr, wd, size,
    output rd, gpio_out, misalign
  );
endinterface

// File: rtl/store_lane_gen.sv
// Store lane steering: size + addr[1:0] + wd -> byte enables and replicated lane data.
// Latency: purely combinational.
// Backpressure: none.
// Ports: size_i funct3[1:0], addr_lo_i addr[1:0], wd_i store data,
// be_o byte enables, data_o lane data, misaligned_o natural-alignment violation.
// misaligned_o is only consumed when DMEM_MISALIGN_TRAP_EN is defined.
module store_lane_gen
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wd_i,
  output logic [3:0]  be_o,
  output logic [31:0] data_o,
  output logic        misaligned_o
);

  always_comb begin
    be_o         = 4'b1111;
    data_o       = wd_i;
    misaligned_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        be_o   = 4'b0001 << addr_lo_i;
        data_o = {4{wd_i[7:0]}};
      end
      SZ_HALF: begin
        // addr[0] is ignored for lane selection; it only flags misalignment.
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        data_o       = {2{wd_i[15:0]}};
        misaligned_o = addr_lo_i[0];
      end
      default: begin
        misaligned_o = (addr_lo_i != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: RAM array plus GPIO / 64-bit cycle counter / STATUS MMIO.
// Latency: reads combinational (0 cycles); writes commit at the next rising edge.
// Backpressure: none; requests are always accepted.
// Ports: clk, reset (sync active-high), bus (dmem_responder_if.slave).
// Build option: DMEM_MISALIGN_TRAP_EN enables misalignment detection, store
// suppression and the sticky misalign/STATUS flag; otherwise misalign is 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int GPIO_W    = 8
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [31:0]       mem_q [MEM_WORDS];
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic [31:0]       cyc_lo_q, cyc_lo_d;
  logic [31:0]       cyc_hi_q, cyc_hi_d;
  logic              misalign_flag;

  logic              is_mmio;
  logic [IDX_W-1:0]  word_idx;
  logic [3:0]        mmio_off;
  logic [3:0]        be;
  logic [31:0]       lane_dat;
  logic              lane_mis;
  logic              wr_en;
  logic [31:0]       gpio_ext;
  logic [31:0]       rd_word;

  // Upper RAM address bits alias onto the array.
  logic unused_addr;
  assign unused_addr = ^bus.addr[30:IDX_W+2];

  assign is_mmio  = bus.addr[MMIO_BIT];
  assign word_idx = bus.addr[IDX_W+1:2];
  assign mmio_off = bus.addr[3:0];

  store_lane_gen u_lane (
    .size_i       (bus.size),
    .addr_lo_i    (bus.addr[1:0]),
    .wd_i         (bus.wd),
    .be_o         (be),
    .data_o       (lane_dat),
    .misaligned_o (lane_mis)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_req, mis_q, mis_d, status_clr;

  assign mis_req    = (bus.we | bus.re) & lane_mis;
  assign wr_en      = bus.we & ~mis_req;
  assign status_clr = wr_en & is_mmio & (mmio_off == OFF_STATUS)
                    & be[STATUS_MIS_BIT/8] & lane_dat[STATUS_MIS_BIT];

  // A new misalignment in the same cycle as a clear keeps the flag set.
  always_comb begin
    mis_d = mis_q;
    if (status_clr) mis_d = 1'b0;
    if (mis_req)    mis_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end

  assign misalign_flag = mis_q;
`else
  logic unused_mis;
  assign unused_mis    = lane_mis | bus.re;
  assign wr_en         = bus.we;
  assign misalign_flag = 1'b0;
`endif

  // RAM is never reset, so a store coinciding with reset still lands.
  always_ff @(posedge clk) begin
    if (wr_en && !is_mmio) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= lane_dat[8*b +: 8];
      end
    end
  end

  // GPIO honours byte enables; bytes beyond GPIO_W simply have no bits to land in.
  always_comb begin
    gpio_d = gpio_q;
    if (wr_en && is_mmio && (mmio_off == OFF_GPIO)) begin
      for (int i = 0; i < GPIO_W; i++) begin
        if (be[i/8]) gpio_d[i] = lane_dat[i];
      end
    end
  end

  // 64-bit counter kept as two halves; the high half takes the carry out of the low.
  always_comb begin
    cyc_lo_d = cyc_lo_q + 32'd1;
    cyc_hi_d = cyc_hi_q + {31'd0, &cyc_lo_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_q   <= '0;
      cyc_lo_q <= '0;
      cyc_hi_q <= '0;
    end else begin
      gpio_q   <= gpio_d;
      cyc_lo_q <= cyc_lo_d;
      cyc_hi_q <= cyc_hi_d;
    end
  end

  always_comb begin
    gpio_ext                = '0;
    gpio_ext[GPIO_W-1:0]    = gpio_q;
    rd_word                 = mem_q[word_idx];
    if (is_mmio) begin
      case (mmio_off)
        OFF_GPIO:   rd_word = gpio_ext;
        OFF_CYC_LO: rd_word = cyc_lo_q;
        OFF_CYC_HI: rd_word = cyc_hi_q;
        OFF_STATUS: rd_word = {31'd0, misalign_flag};
        default:    rd_word = '0;
      endcase
    end
  end

  assign bus.rd       = rd_word;
  assign bus.gpio_out = gpio_q;
  assign bus.misalign = misalign_flag;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expectations, a negedge monitor pops and compares.
// Latency: reads checked in the same cycle they are presented.
// Backpressure: none expected from the DUT.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int MEM_WORDS = 1024;
  localparam int GPIO_W    = 8;

  localparam logic [31:0] A_GPIO   = 32'h8000_0000 | {28'd0, OFF_GPIO};
  localparam logic [31:0] A_CYC_LO = 32'h8000_0000 | {28'd0, OFF_CYC_LO};
  localparam logic [31:0] A_CYC_HI = 32'h8000_0000 | {28'd0, OFF_CYC_HI};
  localparam logic [31:0] A_STATUS = 32'h8000_0000 | {28'd0, OFF_STATUS};

  localparam int K_RD   = 0;
  localparam int K_GPIO = 1;
  localparam int K_MIS  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if #(.GPIO_W(GPIO_W)) bus ();

  dmem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .GPIO_W    (GPIO_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  logic probe_vld = 1'b0;
  logic done_req  = 1'b0;
  logic done_ack  = 1'b0;
  int   checks    = 0;
  int   errors    = 0;

  // Monitor: one expectation is consumed per cycle in which the DUT presents a read or a probe.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (bus.re || probe_vld) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output rd=%h with empty scoreboard", bus.rd);
      end else begin
        e = sb_q.pop_front();
        case (e.kind)
          K_RD:    act = bus.rd;
          K_GPIO:  act = 32'(bus.gpio_out);
          default: act = {31'd0, bus.misalign};
        endcase
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
        end
      end
    end
    if (done_req && !done_ack) begin
      checks++;
      if (sb_q.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
      end
      done_ack = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] s);
    bus.we   = w;
    bus.re   = r;
    bus.addr = a;
    bus.wd   = d;
    bus.size = s;
  endtask

  task automatic expect_push(input int k, input logic [31:0] e, input string n);
    exp_t x;
    x.kind = k;
    x.exp  = e;
    x.name = n;
    sb_q.push_back(x);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    drive(1'b1, 1'b0, a, d, s);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, SZ_WORD);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] e, input string n);
    drive(1'b0, 1'b1, a, 32'd0, SZ_WORD);
    expect_push(K_RD, e, n);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, SZ_WORD);
  endtask

  // we and re together: the store lands at the edge, rd shows the pre-edge word.
  task automatic store_load(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                            input logic [31:0] e, input string n);
    drive(1'b1, 1'b1, a, d, s);
    expect_push(K_RD, e, n);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, SZ_WORD);
  endtask

  task automatic probe(input int k, input logic [31:0] e, input string n);
    drive(1'b0, 1'b0, 32'd0, 32'd0, SZ_WORD);
    probe_vld = 1'b1;
    expect_push(k, e, n);
    tick();
    probe_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 32'd0, 32'd0, SZ_WORD);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout sim time exceeded");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, SZ_WORD);
    tick();
    tick();
    reset = 1'b0;

    // Cycle count is 0 in the first cycle after reset and +1 per following cycle.
    load(A_CYC_LO, 32'd0, "cyc_lo_reset");          // cycle 0
    load(A_CYC_HI, 32'd0, "cyc_hi_reset");          // cycle 1
    probe(K_GPIO, 32'd0, "gpio_reset");             // cycle 2
    probe(K_MIS,  32'd0, "misalign_reset");         // cycle 3
    load(A_CYC_LO, 32'd4, "cyc_lo_t0");             // cycle 4
    idle(5);                                        // cycles 5..9
    load(A_CYC_LO, 32'd10, "cyc_lo_t0_plus_6");     // cycle 10

    store(32'h10, 32'hDEAD_BEEF, SZ_WORD);
    load(32'h10, 32'hDEAD_BEEF, "sw_lw");

    store(32'h10, 32'h0000_0000, SZ_WORD);
    store(32'h11, 32'h1234_56AA, SZ_BYTE);
    load(32'h10, 32'h0000_AA00, "sb_lane1");
    store(32'h12, 32'hBEEF_1234, SZ_HALF);
    load(32'h10, 32'h1234_AA00, "sh_upper");
    store(32'h13, 32'h0000_0077, SZ_BYTE);
    store(32'h10, 32'h0000_5566, SZ_HALF);
    load(32'h10, 32'h7734_5566, "sb3_sh_lower");

    store(32'h40, 32'h89AB_CDEF, SZ_WORD_X);
    load(32'h40, 32'h89AB_CDEF, "size11_word");

    store(MEM_WORDS * 4 + 32'h8, 32'h0000_0055, SZ_WORD);
    load(32'h8, 32'h0000_0055, "alias_depth");
    load(32'h7FFF_F008, 32'h0000_0055, "alias_high_bits");

    store(32'h20, 32'h1111_1111, SZ_WORD);
    store_load(32'h20, 32'hCAFE_F00D, SZ_WORD, 32'h1111_1111, "we_re_old_data");
    load(32'h20, 32'hCAFE_F00D, "we_re_committed");

    store(A_GPIO, 32'h0000_00FF, SZ_BYTE);
    probe(K_GPIO, 32'h0000_00FF, "gpio_sb");
    load(A_GPIO, 32'h0000_00FF, "gpio_rd_zext");
    store(A_GPIO + 32'd1, 32'h0000_0012, SZ_BYTE);
    probe(K_GPIO, 32'h0000_00FF, "gpio_lane1_dropped");
    store(A_GPIO, 32'h0000_003C, SZ_HALF);
    probe(K_GPIO, 32'h0000_003C, "gpio_sh");
    store(A_CYC_LO, 32'hFFFF_FFFF, SZ_WORD);
    load(32'h8000_0002, 32'h0000_0000, "mmio_unmapped");

    // Reset asserted during a RAM store: MMIO clears, the store still lands.
    drive(1'b1, 1'b0, 32'h30, 32'hA5A5_A5A5, SZ_WORD);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, SZ_WORD);
    load(A_CYC_LO, 32'd0, "cyc_lo_restart");
    load(A_CYC_HI, 32'd0, "cyc_hi_restart");
    probe(K_GPIO, 32'd0, "gpio_after_reset");
    load(32'h30, 32'hA5A5_A5A5, "ram_write_in_reset");

    store(32'h4, 32'h4444_4444, SZ_WORD);
    store(32'h6, 32'h0000_0001, SZ_WORD);
`ifdef DMEM_MISALIGN_TRAP_EN
    probe(K_MIS, 32'd1, "misalign_set");
    load(32'h4, 32'h4444_4444, "misaligned_sw_blocked");
    load(A_STATUS, 32'd1, "status_set");
    // Misaligned half access that also writes 1 to STATUS: set must win.
    store_load(A_STATUS + 32'd1, 32'h0000_0001, SZ_HALF, 32'd0, "mmio_off_d_reads0");
    probe(K_MIS, 32'd1, "set_beats_clear");
    store(A_STATUS, 32'h0000_0001, SZ_WORD);
    probe(K_MIS, 32'd0, "misalign_cleared");
    load(A_STATUS, 32'd0, "status_cleared");
`else
    probe(K_MIS, 32'd0, "misalign_tied0");
    load(32'h4, 32'h0000_0001, "sw_ignores_addr_lo");
    store(32'h5, 32'h0000_ABCD, SZ_HALF);
    load(32'h4, 32'h0000_ABCD, "sh_ignores_addr0");
    load(A_STATUS, 32'd0, "status_reads0");
`endif

    // Low half held at all-ones across one edge: the carry must reach the high half.
    load(A_CYC_HI, 32'd0, "cyc_hi_pre_wrap");
    force dut.cyc_lo_q = 32'hFFFF_FFFF;
    idle(1);
    release dut.cyc_lo_q;
    load(A_CYC_HI, 32'd1, "cyc_hi_carry");

    done_req = 1'b1;
    for (int i = 0; i < 10 && !done_ack; i++) tick();
    if (!done_ack) begin
      $display("FAIL monitor_drain_timeout actual=no_ack required=ack");
      $fatal(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
